datamem_arbiter: RTL and testbench

DATAMEM_ARBITER -- requirements
Module: datamem_arbiter

---
 rtl/datamem_arbiter.sv | 113 +++++++++++
 tb/tb_datamem_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/datamem_arbiter.sv
// datamem_arbiter: single-port data memory arbiter between CPU MEM stage and a debug/loader port
module datamem_arbiter #(
  parameter int DW     = 64,
  parameter int AW     = 64,
  parameter int STARVE = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ReadMem,
  input  logic          MemWr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          err_both
);
  localparam int SW = ($clog2(STARVE + 1) > 3) ? $clog2(STARVE + 1) : 3;
  typedef enum logic [1:0] {IDLE, CPU_ACC, DBG_ACC} state_t;
  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          rd_q, rd_d, wr_q, wr_d, err_q, err_d, rvalid_q, rvalid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
  logic          cpu_req, idle, done, starved, gnt_cpu, gnt_dbg;
  assign cpu_req = ReadMem | MemWr;
  assign idle    = state_q == IDLE;
  assign done    = !idle && mem_ready;
  assign starved = starve_q == SW'(STARVE);
  assign gnt_cpu = idle && cpu_req && (!dbg_req || !starved);
  assign gnt_dbg = idle && dbg_req && !gnt_cpu;
  // A simultaneous load+store request is treated as a store only
  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    rvalid_d    = 1'b0;
    err_d       = err_q | (ReadMem & MemWr);
    starve_d    = (!dbg_req || gnt_dbg) ? '0 : (gnt_cpu && !starved) ? starve_q + 1'b1 : starve_q;
    if (gnt_cpu) begin
      state_d = CPU_ACC;
      rd_d    = ReadMem & ~MemWr;
      wr_d    = MemWr;
      addr_d  = cpu_addr;
      wdata_d = cpu_wdata;
    end else if (gnt_dbg) begin
      state_d = DBG_ACC;
      rd_d    = ~dbg_we;
      wr_d    = dbg_we;
      addr_d  = dbg_addr;
      wdata_d = dbg_wdata;
    end else if (done) begin
      state_d     = IDLE;
      rd_d        = 1'b0;
      wr_d        = 1'b0;
      cpu_rdata_d = (rd_q && state_q == CPU_ACC) ? mem_rdata : cpu_rdata_q;
      dbg_rdata_d = (rd_q && state_q == DBG_ACC) ? mem_rdata : dbg_rdata_q;
      rvalid_d    = rd_q && state_q == DBG_ACC;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      rvalid_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      err_q       <= err_d;
      rvalid_q    <= rvalid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end
  // Grant is the combinational accept strobe, held low while in reset
  assign dbg_gnt    = reset & gnt_dbg;
  assign cpu_stall  = cpu_req && !(state_q == CPU_ACC && mem_ready);
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign dbg_rvalid = rvalid_q;
  assign mem_rd     = rd_q;
  assign mem_wr     = wr_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign err_both   = err_q;
endmodule

// File: tb/tb_datamem_arbiter.sv
// tb_datamem_arbiter: cycle vectors, corner-case sequences and a random run against a reference model
module tb_datamem_arbiter;
  localparam int DW = 32, AW = 32, ST = 4;
  logic clk = 1'b0, reset = 1'b0;
  logic ReadMem = 1'b0, MemWr = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0, mem_ready = 1'b0;
  logic [AW-1:0] cpu_addr = '0, dbg_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, dbg_wdata = '0, mem_rdata = '0;
  logic cpu_stall, dbg_gnt, dbg_rvalid, mem_rd, mem_wr, err_both;
  logic [DW-1:0] cpu_rdata, dbg_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  datamem_arbiter #(.DW(DW), .AW(AW), .STARVE(ST)) dut (
    .clk(clk), .reset(reset), .ReadMem(ReadMem), .MemWr(MemWr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .dbg_req(dbg_req),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .err_both(err_both)
  );
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic idle_inputs;
    {ReadMem, MemWr, dbg_req, dbg_we, mem_ready} = 5'b0;
    cpu_addr = '0; dbg_addr = '0; cpu_wdata = '0; dbg_wdata = '0; mem_rdata = '0;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // ctl = {ReadMem,MemWr,dbg_req,dbg_we,mem_ready}; eb = {cpu_stall,mem_rd,mem_wr,dbg_gnt,dbg_rvalid}
  typedef struct {
    logic [4:0] ctl; logic [AW-1:0] addr; logic [DW-1:0] wd, rdata;
    logic [4:0] eb;  logic [AW-1:0] maddr; logic [DW-1:0] mwd, crd, drd;
  } vec_t;
  vec_t tbl[12];
  int m_st, m_cnt, n;
  logic m_rd, m_wr, m_rv, c_req, win_c, win_d, nrv;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd, m_crd, m_drd;
  initial begin
    tbl[0]  = '{5'b10000, 32'h8,  32'h0,  32'h0,    5'b10000, 32'h0,  32'h0,  32'h0,    32'h0};
    tbl[1]  = '{5'b10000, 32'h8,  32'h0,  32'h0,    5'b11000, 32'h8,  32'h0,  32'h0,    32'h0};
    tbl[2]  = '{5'b10001, 32'h8,  32'h0,  32'hDEAD, 5'b01000, 32'h8,  32'h0,  32'h0,    32'h0};
    tbl[3]  = '{5'b00000, 32'h0,  32'h0,  32'h0,    5'b00000, 32'h8,  32'h0,  32'hDEAD, 32'h0};
    tbl[4]  = '{5'b00110, 32'h10, 32'h55, 32'h0,    5'b00010, 32'h8,  32'h0,  32'hDEAD, 32'h0};
    tbl[5]  = '{5'b00000, 32'h0,  32'h0,  32'h0,    5'b00100, 32'h10, 32'h55, 32'hDEAD, 32'h0};
    tbl[6]  = '{5'b00001, 32'h0,  32'h0,  32'h0,    5'b00100, 32'h10, 32'h55, 32'hDEAD, 32'h0};
    tbl[7]  = '{5'b00001, 32'h0,  32'h0,  32'h0,    5'b00000, 32'h10, 32'h55, 32'hDEAD, 32'h0};
    tbl[8]  = '{5'b00100, 32'h20, 32'h0,  32'h0,    5'b00010, 32'h10, 32'h55, 32'hDEAD, 32'h0};
    tbl[9]  = '{5'b10001, 32'h20, 32'h0,  32'h1234, 5'b11000, 32'h20, 32'h0,  32'hDEAD, 32'h0};
    tbl[10] = '{5'b00000, 32'h0,  32'h0,  32'h0,    5'b00001, 32'h20, 32'h0,  32'hDEAD, 32'h1234};
    tbl[11] = '{5'b00000, 32'h0,  32'h0,  32'h0,    5'b00000, 32'h20, 32'h0,  32'hDEAD, 32'h1234};
    ReadMem = 1'b1; dbg_req = 1'b1; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", 64'({mem_rd, mem_wr, dbg_gnt, dbg_rvalid, err_both}), 64'(0));
    chk("rst_data", 64'({cpu_rdata, dbg_rdata}), 64'(0));
    chk("rst_addr", 64'({mem_addr, mem_wdata}), 64'(0));
    idle_inputs();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      {ReadMem, MemWr, dbg_req, dbg_we, mem_ready} = tbl[i].ctl;
      cpu_addr = tbl[i].addr; dbg_addr = tbl[i].addr;
      cpu_wdata = tbl[i].wd; dbg_wdata = tbl[i].wd; mem_rdata = tbl[i].rdata;
      #2;
      chk($sformatf("tbl%0d.flags", i), 64'({cpu_stall, mem_rd, mem_wr, dbg_gnt, dbg_rvalid}), 64'(tbl[i].eb));
      chk($sformatf("tbl%0d.maddr", i), 64'(mem_addr), 64'(tbl[i].maddr));
      chk($sformatf("tbl%0d.mwdata", i), 64'(mem_wdata), 64'(tbl[i].mwd));
      chk($sformatf("tbl%0d.cpu_rdata", i), 64'(cpu_rdata), 64'(tbl[i].crd));
      chk($sformatf("tbl%0d.dbg_rdata", i), 64'(dbg_rdata), 64'(tbl[i].drd));
      chk($sformatf("tbl%0d.err", i), 64'(err_both), 64'(0));
      step();
    end
    // Continuous contention: four CPU reads then one debug write, repeating
    ReadMem = 1'b1; dbg_req = 1'b1; dbg_we = 1'b1; mem_ready = 1'b1;
    cpu_addr = 32'h100; dbg_addr = 32'h200;
    n = 0;
    for (int c = 0; c < 40 && n < 10; c++) begin
      #2;
      if (mem_rd | mem_wr) begin
        chk($sformatf("starve_owner%0d", n), 64'({mem_wr, mem_rd}), (n % 5 == 4) ? 64'(2) : 64'(1));
        n++;
      end
      step();
    end
    chk("starve_count", 64'(n), 64'(10));
    idle_inputs();
    step();
    ReadMem = 1'b1; MemWr = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hABCD;
    step();
    #1;
    chk("both_cmd", 64'({mem_rd, mem_wr}), 64'(1));
    chk("both_addr", 64'(mem_addr), 64'(32'h40));
    chk("both_err", 64'(err_both), 64'(1));
    ReadMem = 1'b0; MemWr = 1'b0; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    repeat (3) step();
    chk("both_err_sticky", 64'({err_both, mem_wr}), 64'(2));
    reset = 1'b0;
    #1;
    chk("both_err_reset", 64'(err_both), 64'(0));
    step();
    reset = 1'b1;
    MemWr = 1'b1; cpu_addr = 32'h44;
    step();
    chk("midrst_active", 64'(mem_wr), 64'(1));
    MemWr = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_drop", 64'({mem_rd, mem_wr}), 64'(0));
    chk("midrst_addr", 64'(mem_addr), 64'(0));
    step();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk($sformatf("midrst_noretry%0d", c), 64'({mem_rd, mem_wr, cpu_stall}), 64'(0));
      step();
    end
    // Random run with memory acting on its own schedule
    reset = 1'b0;
    idle_inputs();
    step();
    reset = 1'b1;
    m_st = 0; m_cnt = 0; m_rd = 0; m_wr = 0; m_rv = 0; m_addr = '0; m_wd = '0; m_crd = '0; m_drd = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      n = int'($urandom_range(0, 3));
      ReadMem = n == 1; MemWr = n == 2;
      dbg_req = $urandom_range(0, 9) < 6; dbg_we = 1'($urandom);
      cpu_addr = $urandom; dbg_addr = $urandom; cpu_wdata = $urandom; dbg_wdata = $urandom;
      mem_ready = 1'($urandom); mem_rdata = $urandom;
      #2;
      c_req = ReadMem | MemWr;
      win_c = m_st == 0 && c_req && (!dbg_req || m_cnt < ST);
      win_d = m_st == 0 && dbg_req && !win_c;
      chk("rnd.stall", 64'(cpu_stall), 64'(c_req && !(m_st == 1 && mem_ready)));
      chk("rnd.gnt", 64'(dbg_gnt), 64'(win_d));
      chk("rnd.cmd", 64'({mem_rd, mem_wr}), 64'({m_rd, m_wr}));
      chk("rnd.addr", 64'(mem_addr), 64'(m_addr));
      chk("rnd.wdata", 64'(mem_wdata), 64'(m_wd));
      chk("rnd.cpu_rdata", 64'(cpu_rdata), 64'(m_crd));
      chk("rnd.dbg_rdata", 64'(dbg_rdata), 64'(m_drd));
      chk("rnd.rvalid_err", 64'({dbg_rvalid, err_both}), 64'({m_rv, 1'b0}));
      @(posedge clk);
      nrv = m_st == 2 && mem_ready && m_rd;
      if (m_st != 0 && mem_ready) begin
        if (m_rd && m_st == 1) m_crd = mem_rdata;
        if (m_rd && m_st == 2) m_drd = mem_rdata;
        m_st = 0; m_rd = 0; m_wr = 0;
      end else if (win_c) begin
        m_st = 1; m_rd = ReadMem && !MemWr; m_wr = MemWr; m_addr = cpu_addr; m_wd = cpu_wdata;
      end else if (win_d) begin
        m_st = 2; m_rd = !dbg_we; m_wr = dbg_we; m_addr = dbg_addr; m_wd = dbg_wdata;
      end
      m_cnt = (!dbg_req || win_d) ? 0 : (win_c && m_cnt < ST) ? m_cnt + 1 : m_cnt;
      m_rv = nrv;
      #1;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
